// File: rtl/acc_pkg.sv
// Shared definitions for the result output path: FSM states, command codes,
// the error byte and the default result-vector size.
// Optional feature macro: OUTPUT_CHECKSUM_EN (adds the XOR checksum helper).
package acc_pkg;

    localparam int NBYTES_DEFAULT = 1024;

    localparam logic [3:0] CMD_VEC    = 4'd2;
    localparam logic [3:0] CMD_SCALAR = 4'd3;
    localparam logic [7:0] ERR_BYTE   = 8'hEE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_RD = 3'd2,
        LOAD    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5,
        FIN     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        KIND_ERR    = 2'd0,
        KIND_VEC    = 2'd1,
        KIND_SCALAR = 2'd2
    } kind_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Map a nonzero command code onto the kind of payload it requests.
    function automatic kind_t decode_kind(input logic [3:0] cmd);
        kind_t k;
        case (cmd)
            CMD_VEC:    k = KIND_VEC;
            CMD_SCALAR: k = KIND_SCALAR;
            default:    k = KIND_ERR;
        endcase
        return k;
    endfunction

`ifdef OUTPUT_CHECKSUM_EN
    // Running XOR checksum over payload bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx.sv
// UART serializer: 1 start bit, 8 data bits LSB first, 1 stop bit, each
// CLKS_PER_BIT clocks. Tx_Done pulses during the final stop-bit cycle so the
// caller can prepare the next byte without adding idle time on the line.
// CLKS_PER_BIT must be at least 2.
module uart_tx
    import acc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       Tx_DV,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Active,
    output logic       Tx_Serial,
    output logic       Tx_Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_TICK = CW'(CLKS_PER_BIT - 2);

    tx_state_t     state_r;
    logic [CW-1:0] clk_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    byte_r;

    // Frame sequencer; line is driven from a register so reset forces it high at once.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_r   <= TX_IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            byte_r    <= 8'h00;
            Tx_Serial <= 1'b1;
            Tx_Active <= 1'b0;
            Tx_Done   <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    Tx_Serial <= 1'b1;
                    clk_cnt_r <= '0;
                    bit_idx_r <= 3'd0;
                    if (Tx_DV) begin
                        byte_r    <= Tx_Byte;
                        Tx_Serial <= 1'b0;
                        Tx_Active <= 1'b1;
                        state_r   <= TX_START;
                    end
                end
                TX_START: begin
                    if (clk_cnt_r == LAST_TICK) begin
                        clk_cnt_r <= '0;
                        Tx_Serial <= byte_r[0];
                        state_r   <= TX_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clk_cnt_r == LAST_TICK) begin
                        clk_cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            Tx_Serial <= 1'b1;
                            state_r   <= TX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            Tx_Serial <= byte_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (clk_cnt_r == DONE_TICK) begin
                        Tx_Done <= 1'b1;
                    end
                    if (clk_cnt_r == LAST_TICK) begin
                        clk_cnt_r <= '0;
                        Tx_Active <= 1'b0;
                        state_r   <= TX_IDLE;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r   <= TX_IDLE;
                    Tx_Serial <= 1'b1;
                    Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/output_interface.sv
// Result output interface: on a command, streams the result vector (from
// BRAM), the 32-bit scalar, or an error byte over UART, then pulses done.
// Optional feature macro: OUTPUT_CHECKSUM_EN appends an XOR checksum byte.
module output_interface
    import acc_pkg::*;
#(
    parameter int NBytes       = NBYTES_DEFAULT,
    parameter int CLKS_PER_BIT = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  command,
    input  logic [31:0] scalar,
    input  logic [7:0]  bram_rdata,
    output logic        bram_ren,
    output logic [9:0]  bram_addr,
    output logic        uart_tx,
    output logic        done,
    output logic        busy
);

    localparam logic [9:0] LAST_VEC = 10'(NBytes - 1);

    state_t      state_r;
    kind_t       kind_r;
    logic [31:0] scalar_r;
    logic [9:0]  count_r;
    logic [9:0]  last_r;
    logic [7:0]  tx_byte_r;
    logic        tx_dv_r;
    logic        tx_active_s;
    logic        tx_done_s;
    logic [7:0]  pay_byte_s;
`ifdef OUTPUT_CHECKSUM_EN
    logic [7:0]  csum_r;
    logic        csum_phase_r;
`endif

    // Payload byte for the current count, chosen by the request kind.
    always_comb begin
        pay_byte_s = ERR_BYTE;
        case (kind_r)
            KIND_VEC:    pay_byte_s = bram_rdata;
            KIND_SCALAR: pay_byte_s = scalar_r[{count_r[1:0], 3'b000} +: 8];
            KIND_ERR:    pay_byte_s = ERR_BYTE;
            default:     pay_byte_s = ERR_BYTE;
        endcase
    end

    // Main sequencer: accepts requests in IDLE, fetches, loads and sends each byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            kind_r    <= KIND_ERR;
            scalar_r  <= 32'h0;
            count_r   <= 10'd0;
            last_r    <= 10'd0;
            tx_byte_r <= 8'h00;
            tx_dv_r   <= 1'b0;
            bram_ren  <= 1'b0;
            bram_addr <= 10'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef OUTPUT_CHECKSUM_EN
            csum_r       <= 8'h00;
            csum_phase_r <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            tx_dv_r  <= 1'b0;
            bram_ren <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (command != 4'd0) begin
                        busy      <= 1'b1;
                        scalar_r  <= scalar;
                        count_r   <= 10'd0;
                        bram_addr <= 10'd0;
                        kind_r    <= decode_kind(command);
                        case (decode_kind(command))
                            KIND_VEC:    last_r <= LAST_VEC;
                            KIND_SCALAR: last_r <= 10'd3;
                            default:     last_r <= 10'd0;
                        endcase
`ifdef OUTPUT_CHECKSUM_EN
                        csum_r       <= 8'h00;
                        csum_phase_r <= 1'b0;
`endif
                        state_r <= FETCH;
                    end
                end
                FETCH: begin
`ifdef OUTPUT_CHECKSUM_EN
                    bram_ren <= (kind_r == KIND_VEC) && !csum_phase_r;
`else
                    bram_ren <= (kind_r == KIND_VEC);
`endif
                    state_r <= WAIT_RD;
                end
                WAIT_RD: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    // Serializer is normally idle here; wait defensively if not.
                    if (!tx_active_s) begin
`ifdef OUTPUT_CHECKSUM_EN
                        if (csum_phase_r) begin
                            tx_byte_r <= csum_r;
                        end else begin
                            tx_byte_r <= pay_byte_s;
                            csum_r    <= csum_next(csum_r, pay_byte_s);
                        end
`else
                        tx_byte_r <= pay_byte_s;
`endif
                        tx_dv_r <= 1'b1;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    state_r <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_s) begin
`ifdef OUTPUT_CHECKSUM_EN
                        if (csum_phase_r) begin
                            done    <= 1'b1;
                            state_r <= FIN;
                        end else if (count_r != last_r) begin
                            count_r   <= count_r + 10'd1;
                            bram_addr <= count_r + 10'd1;
                            state_r   <= FETCH;
                        end else begin
                            csum_phase_r <= 1'b1;
                            state_r      <= FETCH;
                        end
`else
                        if (count_r != last_r) begin
                            count_r   <= count_r + 10'd1;
                            bram_addr <= count_r + 10'd1;
                            state_r   <= FETCH;
                        end else begin
                            done    <= 1'b1;
                            state_r <= FIN;
                        end
`endif
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .Clock     (clk),
        .reset     (reset),
        .Tx_DV     (tx_dv_r),
        .Tx_Byte   (tx_byte_r),
        .Tx_Active (tx_active_s),
        .Tx_Serial (uart_tx),
        .Tx_Done   (tx_done_s)
    );

endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: UART decoder monitor, BRAM model, expected-byte
// scoreboard, a table of single requests plus hand-written corner sequences.
module tb_output_interface;

    localparam int CPB = 4;
    localparam int NB  = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  command;
    logic [31:0] scalar;
    logic [7:0]  bram_rdata;
    logic        bram_ren;
    logic [9:0]  bram_addr;
    logic        uart_tx;
    logic        done;
    logic        busy;

    output_interface #(.NBytes(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .command    (command),
        .scalar     (scalar),
        .bram_rdata (bram_rdata),
        .bram_ren   (bram_ren),
        .bram_addr  (bram_addr),
        .uart_tx    (uart_tx),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: mem[i] = i+1, one-cycle read latency
    always @(posedge clk) begin
        if (bram_ren) bram_rdata <= 8'(bram_addr + 10'd1);
    end

    // Monitor state (written only by the monitor process)
    int         rx_state = 0;
    int         rx_cnt = 0;
    int         idle_cnt = 0;
    int         cur_gap = 0;
    logic [7:0] rx_sh;
    bit         rx_bad;
    logic [7:0] rx_buf[256];
    int         gap_buf[256];
    int         rx_n = 0;
    int         frame_err_n = 0;
    int         done_n = 0;
    int         done_busy_bad = 0;
    logic [9:0] addr_buf[256];
    int         addr_n = 0;

    // UART decoder, done/busy watcher and BRAM address logger, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            rx_state = 0;
            idle_cnt = 0;
        end else begin
            if (done) begin
                done_n++;
                if (!busy) done_busy_bad++;
            end
            if (bram_ren) begin
                addr_buf[addr_n % 256] = bram_addr;
                addr_n++;
            end
            if (rx_state == 0) begin
                if (uart_tx == 1'b0) begin
                    rx_state = 1;
                    rx_cnt   = 0;
                    cur_gap  = idle_cnt - (CPB - CPB/2 - 1);
                    rx_bad   = 1'b0;
                end else begin
                    idle_cnt++;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB/2) begin
                    if (rx_cnt / CPB == 0) begin
                        if (uart_tx !== 1'b0) rx_bad = 1'b1;
                    end else if (rx_cnt / CPB <= 8) begin
                        rx_sh[rx_cnt / CPB - 1] = uart_tx;
                    end else begin
                        if (uart_tx !== 1'b1) rx_bad = 1'b1;
                        rx_buf[rx_n % 256]  = rx_sh;
                        gap_buf[rx_n % 256] = cur_gap;
                        if (rx_bad) frame_err_n++;
                        rx_n++;
                        rx_state = 0;
                        idle_cnt = 0;
                    end
                end
            end
        end
    end

    // Scoreboard and counters (written only by the stimulus process)
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int s_rx, s_done, s_addr, s_fe, s_dbb;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] sc;
        logic [63:0] exp_bytes;
        int          exp_len;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_rx   = rx_n;
        s_done = done_n;
        s_addr = addr_n;
        s_fe   = frame_err_n;
        s_dbb  = done_busy_bad;
    endtask

    task automatic push_exp(input logic [63:0] b, input int len, output int total);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(b[8*i +: 8]);
            cs = cs ^ b[8*i +: 8];
        end
`ifdef OUTPUT_CHECKSUM_EN
        exp_q.push_back(cs);
        total = len + 1;
`else
        total = len;
`endif
    endtask

    task automatic drive_cmd(input logic [3:0] cmd, input logic [31:0] sc);
        @(posedge clk); #1;
        command = cmd;
        scalar  = sc;
        @(posedge clk); #1;
        command = 4'd0;
        scalar  = ~sc;
    endtask

    task automatic finish_txn(input int total, input int exp_done, input int skip_a,
                              input int skip_b, input bit is_vec, input string name);
        int t;
        int got;
        int idx;
        logic [7:0] e;
        t = 0;
        while (done_n < s_done + exp_done && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check({name, " done_in_time"}, 64'(done_n >= s_done + exp_done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, " done_count"}, 64'(done_n - s_done), 64'(exp_done));
        check({name, " busy_at_done"}, 64'(done_busy_bad - s_dbb), 64'd0);
        got = rx_n - s_rx;
        check({name, " byte_count"}, 64'(got), 64'(total));
        for (int i = 0; i < got; i++) begin
            idx = (s_rx + i) % 256;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s unexpected_byte: got %0h expected none", name, rx_buf[idx]);
            end else begin
                e = exp_q.pop_front();
                check({name, " byte"}, 64'(rx_buf[idx]), 64'(e));
            end
            if (i > 0 && i != skip_a && i != skip_b)
                check({name, " gap_le4"}, 64'(gap_buf[idx] <= 4), 64'd1);
        end
        check({name, " missing_bytes"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check({name, " frame_err"}, 64'(frame_err_n - s_fe), 64'd0);
        check({name, " busy_after"}, 64'(busy), 64'd0);
        check({name, " line_idle"}, 64'(uart_tx), 64'd1);
        if (is_vec) begin
            check({name, " addr_count"}, 64'(addr_n - s_addr), 64'(NB));
            for (int i = 0; i < NB && i < addr_n - s_addr; i++)
                check({name, " addr_seq"}, 64'(addr_buf[(s_addr + i) % 256]), 64'(i));
        end
    endtask

    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] sc, input logic [63:0] b,
                           input int len, input bit inject, input string name);
        int total;
        snap();
        push_exp(b, len, total);
        drive_cmd(cmd, sc);
        check({name, " busy_on_accept"}, 64'(busy), 64'd1);
        if (inject) begin
            repeat (60) @(posedge clk);
            #1;
            command = 4'd2;
            @(posedge clk); #1;
            command = 4'd0;
            check({name, " still_busy"}, 64'(busy), 64'd1);
        end
        finish_txn(total, 1, -1, -1, (cmd == 4'd2), name);
    endtask

    initial begin
        int t;
        int t1, t2, t3;
        command = 4'd0;
        scalar  = 32'h0;
        reset   = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("reset uart_tx", 64'(uart_tx), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset bram_ren", 64'(bram_ren), 64'd0);
        check("reset bram_addr", 64'(bram_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        tbl[0] = '{cmd: 4'd3,  sc: 32'h1234ABCD, exp_bytes: 64'h00000000_1234ABCD, exp_len: 4};
        tbl[1] = '{cmd: 4'd2,  sc: 32'h0,        exp_bytes: 64'h08070605_04030201, exp_len: 8};
        tbl[2] = '{cmd: 4'd9,  sc: 32'h0,        exp_bytes: 64'h00000000_000000EE, exp_len: 1};
        tbl[3] = '{cmd: 4'd1,  sc: 32'hFFFFFFFF, exp_bytes: 64'h00000000_000000EE, exp_len: 1};
        tbl[4] = '{cmd: 4'd15, sc: 32'h0,        exp_bytes: 64'h00000000_000000EE, exp_len: 1};
        tbl[5] = '{cmd: 4'd3,  sc: 32'h00FF8001, exp_bytes: 64'h00000000_00FF8001, exp_len: 4};

        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].cmd, tbl[i].sc, tbl[i].exp_bytes, tbl[i].exp_len, 1'b0,
                    $sformatf("tbl%0d", i));

        // Command pulsed while a vector transfer is in flight is ignored
        run_txn(4'd2, 32'h0, 64'h08070605_04030201, 8, 1'b1, "busy_ignore");

        // Request during done cycle ignored; request the cycle after done accepted
        snap();
        push_exp(64'h00000000_A5C30F96, 4, t1);
        drive_cmd(4'd3, 32'hA5C30F96);
        t = 0;
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("b2b first_done_seen", 64'(done), 64'd1);
        command = 4'd9;
        @(posedge clk); #1;
        command = 4'd0;
        @(negedge clk);
        check("same_cycle_req ignored", 64'(busy), 64'd0);
        push_exp(64'h00000000_000000EE, 1, t2);
        drive_cmd(4'd9, 32'h0);
        t = 0;
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("b2b second_done_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
        command = 4'd3;
        scalar  = 32'h5566_7788;
        push_exp(64'h00000000_55667788, 4, t3);
        @(posedge clk); #1;
        command = 4'd0;
        scalar  = 32'h0;
        check("b2b next_cycle accepted", 64'(busy), 64'd1);
        finish_txn(t1 + t2 + t3, 3, t1, t1 + t2, 1'b0, "b2b");

        // Reset during 5th data bit of the 2nd vector byte
        snap();
        drive_cmd(4'd2, 32'h0);
        t = 0;
        while (!(rx_n == s_rx + 1 && rx_state == 1 && rx_cnt == CPB/2 + 5*CPB) && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        check("rst reached_2nd_byte_bit4", 64'(rx_n == s_rx + 1 && rx_state == 1), 64'd1);
        check("rst first_byte", 64'(rx_buf[s_rx % 256]), 64'h01);
        reset = 1'b1;
        #1;
        check("rst uart_tx_high", 64'(uart_tx), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst bram_ren", 64'(bram_ren), 64'd0);
        check("rst bram_addr", 64'(bram_addr), 64'd0);
        repeat (3) @(negedge clk);
        check("rst no_done", 64'(done_n - s_done), 64'd0);
        check("rst line_held_high", 64'(uart_tx), 64'd1);
        reset = 1'b0;
        run_txn(4'd3, 32'hCAFE0B1E, 64'h00000000_CAFE0B1E, 4, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 Parameter NBytes, default 1024: number of bytes in the result vector BRAM.
REQ-002 Parameter CLKS_PER_BIT, default 100: UART bit period in clk cycles.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 command  input  4  result instruction; nonzero for one cycle = request.
REQ-006 scalar  input  32  scalar result (dot product), sampled at request acceptance.
REQ-007 bram_rdata  input  8  result BRAM read data, valid 1 cycle after bram_ren.
REQ-008 bram_ren  output  1  result BRAM read enable.
REQ-009 bram_addr  output  10  result BRAM read address.
REQ-010 uart_tx  output  1  serial transmit line; idle high.
REQ-011 done  output  1  one-cycle pulse when a transmission completes.
REQ-012 busy  output  1  high from request acceptance until the done pulse, inclusive.

Function
REQ-013 The block SHALL accept a request only in IDLE; nonzero command while busy is ignored.
REQ-014 Command codes: 4'd2 = CMD_VEC (send NBytes from BRAM, address 0 upward); 4'd3 = CMD_SCALAR (send the 4 scalar bytes, LSB first); any other nonzero value = send the single error byte 8'hEE.
REQ-015 FSM states: IDLE, FETCH, WAIT_RD, LOAD, SEND, WAIT_TX, FIN.
- IDLE -> FETCH on accepted request.
- FETCH -> WAIT_RD (bram_ren=1 for CMD_VEC only).
- WAIT_RD -> LOAD.
- LOAD -> SEND: byte latched.
- SEND -> WAIT_TX: Tx_DV pulsed one cycle.
- WAIT_TX -> FETCH on Tx_Done if more bytes remain, else -> FIN.
- FIN -> IDLE: done=1.
REQ-016 The byte counter SHALL be 10 bits wide; the last byte is at count NBytes-1 (vector), 3 (scalar) or 0 (error); there is no wrap past NBytes-1.
REQ-017 bram_addr SHALL equal the byte counter and be held stable while bram_ren is high.
REQ-018 Consecutive bytes SHALL be separated by no more than 4 idle clk cycles after the stop bit.
REQ-019 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles.
REQ-020 A request and done SHALL never occur in the same cycle; the earliest new request is accepted in the cycle after the done pulse.

Reset
REQ-021 When reset is asserted, the block SHALL immediately force: state=IDLE, counter=0, bram_ren=0, bram_addr=0, done=0, busy=0, uart_tx=1.
REQ-022 Reset asserted mid-frame SHALL abort the transmission without emitting done; after reset the line is high and the block is idle.

Configuration
REQ-023 With macro OUTPUT_CHECKSUM_EN defined, the block SHALL append one extra byte after every payload: the XOR of all payload bytes. done follows that byte.
REQ-024 Without OUTPUT_CHECKSUM_EN, only the payload is sent and no checksum logic is present.

Structure
REQ-025 Shared package acc_pkg SHALL hold the state enum, the CMD_VEC/CMD_SCALAR codes, ERR_BYTE=8'hEE and the NBytes default.
REQ-026 Serialization SHALL reside in a sub-module uart_tx.
- Ports: Clock, reset, Tx_DV, Tx_Byte[7:0], Tx_Active, Tx_Serial, Tx_Done.
- Parameter: CLKS_PER_BIT.

Verification
REQ-027 CMD_SCALAR, scalar=32'h1234ABCD, CLKS_PER_BIT=4 -> bytes CD, AB, 34, 12 decoded on uart_tx; one done pulse; busy low afterwards.
REQ-028 CMD_VEC, NBytes=8, BRAM[i]=i+1 -> bytes 01..08 in order; bram_addr sequence 0..7; done once; with OUTPUT_CHECKSUM_EN an extra byte 08 follows.
REQ-029 command=4'd9 -> single byte EE, then done; command=4'd2 pulsed during transmission -> ignored, byte count unchanged.
REQ-030 Reset asserted at the 5th bit of the 2nd vector byte -> uart_tx=1 within the same cycle, no done pulse, next CMD_SCALAR transmits correctly.
REQ-031 Back-to-back: request the cycle after done -> accepted; request in the same cycle as done -> not possible (busy high), confirmed by assertion.
